// File: rtl/kyber_pkg.sv
// Shared constants for the Kyber encryption input loader: section codes,
// FSM state encodings, the default module rank and the section length helper.
package kyber_pkg;

   localparam int KYBER_K_DEFAULT = 3;

   // Section tags carried on s_type / input_type / data_type
   localparam logic [3:0] SEC_R   = 4'd1;
   localparam logic [3:0] SEC_EK  = 4'd2;
   localparam logic [3:0] SEC_M   = 4'd3;
   localparam logic [3:0] SEC_AUX = 4'd4;

   // Loader FSM states
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] WAIT   = 3'd1;
   localparam logic [2:0] STREAM = 3'd2;
   localparam logic [2:0] FULL   = 3'd3;
   localparam logic [2:0] HOLD   = 3'd4;

   // Byte length of a section; unknown tags have length 0 and never stream
   function automatic int sec_len(input logic [3:0] t, input int k);
      case (t)
         SEC_R:   return 32;
         SEC_EK:  return 384 * k + 32;
         SEC_M:   return 32;
         SEC_AUX: return 32;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/kyber_byte_reg.sv
// Single-entry output register between the host stream and the core.
// Holds one byte with its index and tag; readin marks it valid. Also forms
// the host-side s_ready so a new byte can land on the edge the old one leaves.
module kyber_byte_reg #(
   parameter int IDX_W   = 16,
   parameter bit DROP_EN = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             stream_ok,
   input  logic             type_match,
   input  logic             room,
   input  logic             s_valid,
   input  logic [7:0]       s_data,
   input  logic [IDX_W-1:0] cnt,
   input  logic [3:0]       tag,
   input  logic             readin_ok,
   output logic             s_ready,
   output logic             load,
   output logic             readin,
   output logic [7:0]       kyber_din,
   output logic [IDX_W-1:0] kyber_in_index,
   output logic [3:0]       data_type
);

   // Matching bytes need space in the register; mismatched bytes are either
   // stalled or, when dropping is enabled, swallowed without touching the core.
   assign s_ready = stream_ok & (type_match ? (room & (~readin | readin_ok)) : DROP_EN);
   assign load    = s_valid & s_ready & type_match;

   // Register fill on host transfer, drain on core transfer; clear aborts the byte
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking <= so every flop sees pre-edge values.
      if (!reset) begin
         readin         <= 1'b0;
         kyber_din      <= '0;
         kyber_in_index <= '0;
         data_type      <= '0;
      end else if (clear) begin
         readin <= 1'b0;
      end else if (load) begin
         readin         <= 1'b1;
         kyber_din      <= s_data;
         kyber_in_index <= cnt;
         data_type      <= tag;
      end else if (readin && readin_ok) begin
         readin <= 1'b0;
      end
   end

endmodule

// File: rtl/kyber_enc_loader.sv
// Upstream feeder for kyber_pke_enc. Accepts a tagged host byte stream and
// serves whichever section the core requests on input_type, one byte per
// cycle over readin/readin_ok, pulsing full_in after each section's last byte.
// Optional build macro: KYBER_LOADER_ERR_EN adds a sticky err output and
// discards host bytes whose tag does not match the section being served.
module kyber_enc_loader
   import kyber_pkg::*;
#(
   parameter int KYBER_K = KYBER_K_DEFAULT,
   parameter int IDX_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [3:0]       s_type,
   input  logic [7:0]       s_data,
   input  logic [3:0]       input_type,
   input  logic             readin_ok,
   input  logic             core_done,
   output logic             readin,
   output logic             full_in,
   output logic [3:0]       data_type,
   output logic [7:0]       kyber_din,
   output logic [IDX_W-1:0] kyber_in_index,
   output logic             busy
`ifdef KYBER_LOADER_ERR_EN
   ,
   output logic             err
`endif
);

`ifdef KYBER_LOADER_ERR_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic [2:0]       state;
   logic [3:0]       typ;
   logic [IDX_W-1:0] cnt;
   logic [IDX_W-1:0] len;
   logic             stream_ok;
   logic             type_match;
   logic             room;
   logic             load;
   logic             core_xfer;
   logic             abort;
   logic             done_ev;
   logic             last;

   assign len        = IDX_W'(sec_len(typ, KYBER_K));
   assign stream_ok  = (state == STREAM) && (input_type == typ);
   assign type_match = (s_type == typ);
   assign room       = (cnt < len);
   assign core_xfer  = readin & readin_ok;
   // A different nonzero request mid-section restarts on the new section
   assign abort      = (state == STREAM) && (input_type != 4'd0) && (input_type != typ);
   assign done_ev    = (state != IDLE) && core_done;
   // All bytes loaded and the final one (index len-1) leaves this edge
   assign last       = (state == STREAM) && (cnt == len) && core_xfer;

   assign full_in = (state == FULL);
   assign busy    = (state != IDLE);

   kyber_byte_reg #(
      .IDX_W   (IDX_W),
      .DROP_EN (DROP_EN)
   ) u_byte_reg (
      .clk            (clk),
      .reset          (reset),
      .clear          (abort | done_ev),
      .stream_ok      (stream_ok),
      .type_match     (type_match),
      .room           (room),
      .s_valid        (s_valid),
      .s_data         (s_data),
      .cnt            (cnt),
      .tag            (typ),
      .readin_ok      (readin_ok),
      .s_ready        (s_ready),
      .load           (load),
      .readin         (readin),
      .kyber_din      (kyber_din),
      .kyber_in_index (kyber_in_index),
      .data_type      (data_type)
   );

   // Run/section FSM with the per-section byte counter; core_done ends any run
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         typ   <= '0;
         cnt   <= '0;
      end else if (done_ev) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (set) begin
                  state <= WAIT;
                  cnt   <= '0;
               end
            end
            WAIT: begin
               if (input_type != 4'd0) begin
                  state <= STREAM;
                  typ   <= input_type;
                  cnt   <= '0;
               end
            end
            STREAM: begin
               if (abort) begin
                  typ <= input_type;
                  cnt <= '0;
               end else if (last) begin
                  state <= FULL;
               end else if (load) begin
                  cnt <= cnt + 1'b1;
               end
            end
            FULL: state <= HOLD;
            HOLD: begin
               if (input_type != typ) state <= WAIT;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef KYBER_LOADER_ERR_EN
   // Sticky error flag: wrong-tag host byte or section abort; cleared by a new run
   always_ff @(posedge clk) begin
      if (!reset) begin
         err <= 1'b0;
      end else if (state == IDLE && set) begin
         err <= 1'b0;
      end else if ((s_valid && s_ready && !type_match) || abort) begin
         err <= 1'b1;
      end
   end
`endif

endmodule
